// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA copy engine.
//   dma_mode_e  : transfer mode captured at start (FILL / COPY)
//   dma_state_e : engine FSM states
//   word_bytes  : byte stride of one memory word
package dma_pkg;

  typedef enum logic {
    DMA_FILL = 1'b0,
    DMA_COPY = 1'b1
  } dma_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COPY   = 2'd2,
    FINISH = 2'd3
  } dma_state_e;

  function automatic int unsigned word_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Small synchronous FIFO buffering COPY read data ahead of the write side.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   i_push      : write i_wdata (ignored when full unless popping the same cycle)
//   i_pop       : drop the head entry (ignored when empty)
//   o_rdata_c   : head entry, combinational read of the storage array
//   o_count     : number of stored entries
//   o_empty     : no entries stored
//   o_full      : DEPTH entries stored
module dma_sync_fifo
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_push,
  input  logic [DATA_W-1:0]                i_wdata,
  input  logic                             i_pop,
  output logic [DATA_W-1:0]                o_rdata_c,
  output logic [$clog2(DEPTH):0]           o_count,
  output logic                             o_empty,
  output logic                             o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_empty;
  logic              r_full;

  logic              w_do_pop;
  logic              w_do_push;
  logic [CNT_W-1:0]  w_count_nxt;

  // A push into a full FIFO is only allowed when the head leaves in the same cycle.
  assign w_do_pop    = i_pop & ~r_empty;
  assign w_do_push   = i_push & (~r_full | w_do_pop);
  assign w_count_nxt = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = r_empty;
  assign o_full    = r_full;

endmodule

// File: rtl/dma_copy_engine.sv
// DMA engine: programmable-length FILL (incrementing pattern) or COPY
// (read source region, buffer in a small FIFO, write destination region).
// One transfer in flight; requests go to a shared memory arbiter port.
// Optional feature: define DMA_CHECKSUM_EN to add output csum, the XOR of
// every word written by the current transfer.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, mode, src_addr,
//   dst_addr, len, fill_base : command, captured when start is seen in IDLE
//   busy, done               : transfer active / one-cycle completion pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata      : memory request, held stable until mem_gnt
//   mem_gnt                  : request accepted this cycle
//   mem_rvalid, mem_rdata    : in-order read return
//   csum                     : (DMA_CHECKSUM_EN only) running XOR of written words
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_base,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W  = FCNT_W + 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(word_bytes(DATA_W));

  dma_state_e        r_state;
  dma_state_e        w_next_state;

  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_fill;
  logic [FCNT_W-1:0] r_out;

  logic              r_busy;
  logic              r_done;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_req_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;

  logic              w_active;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_rv_ok;
  logic              w_last_wr;
  logic              w_issue_slot;
  logic [CNT_W-1:0]  w_wr_cnt_nxt;
  logic [CNT_W-1:0]  w_rd_cnt_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic [DATA_W-1:0] w_fill_nxt;
  logic [OCC_W-1:0]  w_occ;

  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic [DATA_W-1:0] w_fifo_rdata;
  logic [FCNT_W-1:0] w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;

  assign w_active   = (r_state == FILL) || (r_state == COPY);
  assign w_start_ok = start && (r_state == IDLE);
  assign w_accept   = r_mem_req & mem_gnt;
  assign w_wr_acc   = w_accept & r_mem_we;
  assign w_rd_acc   = w_accept & ~r_mem_we;
  // Returns with nothing outstanding (e.g. stragglers after a reset) are dropped.
  assign w_rv_ok    = mem_rvalid & (r_out != '0);

  assign w_wr_cnt_nxt  = r_wr_cnt + CNT_W'(w_wr_acc);
  assign w_rd_cnt_nxt  = r_rd_cnt + CNT_W'(w_rd_acc);
  assign w_wr_addr_nxt = w_wr_acc ? (r_wr_addr + STRIDE) : r_wr_addr;
  assign w_rd_addr_nxt = w_rd_acc ? (r_rd_addr + STRIDE) : r_rd_addr;
  assign w_fill_nxt    = w_wr_acc ? (r_fill + DATA_W'(1)) : r_fill;
  assign w_last_wr     = w_wr_acc && (w_wr_cnt_nxt == r_len);

  // A new request may be chosen when none is pending or the pending one is accepted now.
  assign w_issue_slot = w_active && (!r_mem_req || mem_gnt) && !w_last_wr;

  // Buffered words plus reads in flight, after this cycle's read accept; bounds FIFO fill.
  assign w_occ = OCC_W'(w_fifo_count) + OCC_W'(r_out) + OCC_W'(w_rd_acc);

  assign w_fifo_push = w_rv_ok & ~w_fifo_full;
  assign w_fifo_pop  = w_wr_acc & (r_state == COPY);

  dma_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_fifo_push),
    .i_wdata   (mem_rdata),
    .i_pop     (w_fifo_pop),
    .o_rdata_c (w_fifo_rdata),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len == '0)                             w_next_state = FINISH;
          else if (dma_mode_e'(mode) == DMA_COPY)    w_next_state = COPY;
          else                                       w_next_state = FILL;
        end
      end
      FILL, COPY: if (w_last_wr) w_next_state = FINISH;
      FINISH:     w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered status and request outputs.
  always_comb begin
    w_busy_nxt  = (w_next_state == FILL) || (w_next_state == COPY);
    w_done_nxt  = (r_state == FINISH);
    w_req_nxt   = r_mem_req & ~mem_gnt;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    if (w_issue_slot) begin
      if (r_state == FILL) begin
        if (w_wr_cnt_nxt < r_len) begin
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_wr_addr_nxt;
          w_wdata_nxt = w_fill_nxt;
        end
      end else if (!w_wr_acc) begin
        // COPY: the FIFO head is only valid for a new write once the previous pop has settled.
        if (!w_fifo_empty) begin
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_wr_addr;
          w_wdata_nxt = w_fifo_rdata;
        end else if ((w_rd_cnt_nxt < r_len) && (w_occ < OCC_W'(FIFO_DEPTH))) begin
          w_req_nxt  = 1'b1;
          w_we_nxt   = 1'b0;
          w_addr_nxt = w_rd_addr_nxt;
        end
      end
    end
  end

  // Command capture, progress counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_fill      <= '0;
      r_out       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_start_ok) begin
        r_len     <= CNT_W'(len);
        r_wr_cnt  <= '0;
        r_rd_cnt  <= '0;
        r_wr_addr <= dst_addr;
        r_rd_addr <= src_addr;
        r_fill    <= fill_base;
      end else begin
        r_wr_cnt  <= w_wr_cnt_nxt;
        r_rd_cnt  <= w_rd_cnt_nxt;
        r_wr_addr <= w_wr_addr_nxt;
        r_rd_addr <= w_rd_addr_nxt;
        r_fill    <= w_fill_nxt;
      end
      r_out       <= r_out + FCNT_W'(w_rd_acc) - FCNT_W'(w_rv_ok);
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

`ifdef DMA_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  // XOR of accepted write data; held after done until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst)             r_csum <= '0;
    else if (w_start_ok) r_csum <= '0;
    else if (w_wr_acc)   r_csum <= r_csum ^ r_mem_wdata;
  end

  assign csum = r_csum;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: stimulus pushes expected writes,
// a monitor pops and compares on every accepted write.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [63:0] src_addr = '0;
  logic [63:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic [63:0] fill_base = '0;
  logic        busy, done, mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
`ifdef DMA_CHECKSUM_EN
  logic [63:0] csum;
`endif

  dma_copy_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_base  (fill_base),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef DMA_CHECKSUM_EN
    ,
    .csum       (csum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rd_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_wr[$];
  rd_t rd_pipe[$];
  bit  gnt_rand = 1'b0;
  int  cyc = 0;
  int  done_cnt = 0;
  bit  req_seen = 1'b0;
  int  model_out = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] src_word(input logic [63:0] a);
    return a ^ 64'hA5A5_0000_0000_0000;
  endfunction

  // Memory responder: grant (fixed or random) and in-order read return, latency 3.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_req && mem_gnt && !mem_we)
        rd_pipe.push_back('{cyc + 3, src_word(mem_addr)});
      if (rd_pipe.size() > 0 && rd_pipe[0].due == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_pipe[0].data;
        rd_pipe.delete(0);
      end else begin
        mem_rvalid = 1'b0;
      end
    end
  end

  // Monitor: write scoreboard, request hold, outstanding-read bound, done pulses.
  initial begin
    bit          p_pend = 1'b0;
    logic [63:0] p_addr = '0;
    logic [63:0] p_data = '0;
    logic        p_we = 1'b0;
    wr_t         e;
    bit          rd_acc, rv;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        model_out = 0;
        p_pend    = 1'b0;
      end else begin
        if (mem_req) req_seen = 1'b1;
        if (p_pend) begin
          chk("hold req", 64'(mem_req), 64'd1);
          chk("hold we", 64'(mem_we), 64'(p_we));
          chk("hold addr", mem_addr, p_addr);
          chk("hold wdata", mem_wdata, p_data);
        end
        p_pend = mem_req && !mem_gnt;
        p_addr = mem_addr;
        p_data = mem_wdata;
        p_we   = mem_we;
        if (mem_req && mem_gnt && mem_we) begin
          if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected write: addr %h data %h, none expected", mem_addr, mem_wdata);
          end else begin
            e = exp_wr.pop_front();
            chk("wr addr", mem_addr, e.addr);
            chk("wr data", mem_wdata, e.data);
          end
        end
        rd_acc = mem_req && mem_gnt && !mem_we;
        rv     = mem_rvalid && (model_out > 0);
        model_out = model_out + int'(rd_acc) - int'(rv);
        if (rd_acc) chk("outstanding<=4", 64'(model_out <= 4), 64'd1);
      end
      if (done) begin
        done_cnt++;
        chk("busy low with done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic launch(input logic m, input logic [63:0] s, input logic [63:0] d,
                        input logic [15:0] l, input logic [63:0] b);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk({nm, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, " writes left"}, 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset mem_addr", mem_addr, 64'd0);
    chk("reset mem_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // FILL len=10, grant always
    for (int i = 0; i < 10; i++)
      exp_wr.push_back('{64'h1000 + 64'(8 * i), 64'hDEAD_0000 + 64'(i)});
    launch(1'b0, 64'h0, 64'h1000, 16'd10, 64'hDEAD_0000);
    #2;
    chk("fill busy after start", 64'(busy), 64'd1);
    wait_done("fill10", 200);

    // COPY len=8, random grant
    gnt_rand = 1'b1;
    for (int j = 0; j < 8; j++)
      exp_wr.push_back('{64'h3000 + 64'(8 * j), src_word(64'h2000 + 64'(8 * j))});
    launch(1'b1, 64'h2000, 64'h3000, 16'd8, 64'h0);
    wait_done("copy8", 600);
    gnt_rand = 1'b0;

    // len=0: no traffic, done two cycles after start is sampled
    req_seen = 1'b0;
    d0 = done_cnt;
    launch(1'b0, 64'h0, 64'h7000, 16'd0, 64'h0);
    #2;
    chk("len0 done early", 64'(done), 64'd0);
    chk("len0 busy", 64'(busy), 64'd0);
    @(negedge clk);
    #2;
    chk("len0 done pulse", 64'(done), 64'd1);
    @(negedge clk);
    #2;
    chk("len0 done cleared", 64'(done), 64'd0);
    chk("len0 no mem_req", 64'(req_seen), 64'd0);
    chk("len0 done count", 64'(done_cnt - d0), 64'd1);

    // start while busy is ignored
    gnt_rand = 1'b1;
    for (int i = 0; i < 3; i++)
      exp_wr.push_back('{64'h5000 + 64'(8 * i), 64'h100 + 64'(i)});
    launch(1'b0, 64'h0, 64'h5000, 16'd3, 64'h100);
    #2;
    chk("busy before second start", 64'(busy), 64'd1);
    launch(1'b1, 64'h2000, 64'h9000, 16'd5, 64'h777);
    wait_done("busy start", 300);
    gnt_rand = 1'b0;
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("no extra done", 64'(done_cnt - d0), 64'd0);

    // address wrap
    exp_wr.push_back('{64'hFFFF_FFFF_FFFF_FFF8, 64'h55});
    exp_wr.push_back('{64'h0, 64'h56});
    launch(1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 16'd2, 64'h55);
    wait_done("wrap", 100);

    // reset mid-COPY with reads outstanding
    for (int j = 0; j < 8; j++)
      exp_wr.push_back('{64'h6000 + 64'(8 * j), src_word(64'h4000 + 64'(8 * j))});
    launch(1'b1, 64'h4000, 64'h6000, 16'd8, 64'h0);
    n = 0;
    while (model_out < 3 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("reads outstanding before reset", 64'(model_out >= 3), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort mem_req", 64'(mem_req), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    exp_wr.delete();
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("abort no done", 64'(done_cnt - d0), 64'd0);
    for (int j = 0; j < 2; j++)
      exp_wr.push_back('{64'hA000 + 64'(8 * j), src_word(64'h2100 + 64'(8 * j))});
    launch(1'b1, 64'h2100, 64'hA000, 16'd2, 64'h0);
    wait_done("copy after reset", 200);

`ifdef DMA_CHECKSUM_EN
    for (int i = 0; i < 4; i++)
      exp_wr.push_back('{64'hB000 + 64'(8 * i), 64'd1 + 64'(i)});
    launch(1'b0, 64'h0, 64'hB000, 16'd4, 64'd1);
    wait_done("csum fill", 100);
    chk("csum at done", csum, 64'h4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
